// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue between instruction memory and decode.
// Owns the fetch PC, buffers up to DEPTH {instruction, PC+1} pairs and
// hands them to decode with a valid/ready handshake. Redirects flush the
// queue and restart fetch at the target.
// Optional macro PREFETCH_BYPASS_EN adds a zero-latency path from
// imem_data to the outputs whenever the queue is empty.
module fetch_prefetch_queue #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [WIDTH-1:0]         imem_addr,
   input  logic [WIDTH-1:0]         imem_data,
   input  logic                     redirect,
   input  logic [WIDTH-1:0]         redirect_pc,
   output logic                     instr_valid,
   output logic [WIDTH-1:0]         instr_out,
   output logic [WIDTH-1:0]         pcplus1_out,
   input  logic                     instr_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   logic [WIDTH-1:0] mem_instr [DEPTH];
   logic [WIDTH-1:0] mem_pc1   [DEPTH];

   logic [WIDTH-1:0] fetch_pc_inc;
   logic             queue_push;
   logic             queue_pop;
   logic             pc_advance;

   assign fetch_pc_inc = fetch_pc_q + WIDTH'(1);
   assign imem_addr    = fetch_pc_q;
   assign count        = count_q;
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);

   // Output selection and push/pop decisions for this cycle
   always_comb begin
      instr_valid = ~empty;
      instr_out   = mem_instr[rd_ptr_q];
      pcplus1_out = mem_pc1[rd_ptr_q];
      queue_pop   = ~empty & instr_ready & ~redirect;
      queue_push  = ~redirect & (~full | queue_pop);
      pc_advance  = queue_push;
`ifdef PREFETCH_BYPASS_EN
      if (empty && !redirect) begin
         instr_valid = 1'b1;
         instr_out   = imem_data;
         pcplus1_out = fetch_pc_inc;
         if (instr_ready) begin
            queue_push = 1'b0;
            pc_advance = 1'b1;
         end
      end
`endif
   end

   // Next-state computation for fetch PC, pointers and occupancy
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (pc_advance) fetch_pc_d = fetch_pc_inc;
         if (queue_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (queue_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(queue_push) - CW'(queue_pop);
      end
   end

   // Control state registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= WIDTH'(RESET_PC);
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied
   always_ff @(posedge clk) begin
      if (queue_push) begin
         mem_instr[wr_ptr_q] <= imem_data;
         mem_pc1[wr_ptr_q]   <= fetch_pc_inc;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed testbench for fetch_prefetch_queue (default build, registered path).
// Instruction memory model: imem[a] = 0x100 + a.
module tb_fetch_prefetch_queue;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pcplus1_out;
   logic        instr_ready;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_pc;

   fetch_prefetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_out   (instr_out),
      .pcplus1_out (pcplus1_out),
      .instr_ready (instr_ready),
      .count       (count),
      .full        (full),
      .empty       (empty)
   );

   assign imem_data = 32'h100 + imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b0;
      #12;
      check("reset_count", {29'b0, count}, 32'd0);
      check("reset_empty", {31'b0, empty}, 32'd1);
      check("reset_valid", {31'b0, instr_valid}, 32'd0);
      check("reset_addr", imem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Fill: six cycles with decode stalled
      for (int i = 0; i < 6; i++) begin
         tick();
         check("fill_count_bound", {31'b0, (count <= 3'd4)}, 32'd1);
      end
      check("fill_full", {31'b0, full}, 32'd1);
      check("fill_count", {29'b0, count}, 32'd4);
      check("fill_addr", imem_addr, 32'd4);
      check("fill_head", instr_out, 32'h100);
      check("fill_pc1", pcplus1_out, 32'd1);

      // Stream: pop and push together each cycle
      instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("stream_head", instr_out, 32'h100 + 32'(k));
         check("stream_pc1", pcplus1_out, 32'(k + 1));
         tick();
         check("stream_count", {29'b0, count}, 32'd4);
      end
      check("stream_addr", imem_addr, 32'd8);

      // Redirect while full and ready: head must not be consumed
      redirect = 1'b1;
      redirect_pc = 32'd20;
      check("redir_head_before", instr_out, 32'h104);
      tick();
      check("redir_count", {29'b0, count}, 32'd0);
      check("redir_addr", imem_addr, 32'd20);
      check("redir_valid", {31'b0, instr_valid}, 32'd0);
      redirect = 1'b0;
      instr_ready = 1'b0;
      tick();
      check("redir_valid2", {31'b0, instr_valid}, 32'd1);
      check("redir_instr", instr_out, 32'h114);
      check("redir_pc1", pcplus1_out, 32'd21);
      tick();
      tick();
      check("pre_rst_count", {29'b0, count}, 32'd3);

      // Reset asserted mid-cycle clears state immediately
      #2;
      rst = 1'b0;
      #1;
      check("midrst_count", {29'b0, count}, 32'd0);
      check("midrst_empty", {31'b0, empty}, 32'd1);
      check("midrst_valid", {31'b0, instr_valid}, 32'd0);
      check("midrst_addr", imem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // PC wrap at all-ones
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      tick();
      check("wrap_addr", imem_addr, 32'hFFFF_FFFF);
      redirect = 1'b0;
      tick();
      check("wrap_addr0", imem_addr, 32'd0);
      check("wrap_instr", instr_out, 32'h0000_00FF);
      check("wrap_pc1", pcplus1_out, 32'd0);
      tick();
      tick();
      tick();
      check("wrap_full", {31'b0, full}, 32'd1);
      instr_ready = 1'b1;
      exp_pc = 32'hFFFF_FFFF;
      for (int k = 0; k < 12; k++) begin
         check("wrap_order_instr", instr_out, 32'h100 + exp_pc);
         check("wrap_order_pc1", pcplus1_out, exp_pc + 32'd1);
         tick();
         check("wrap_order_count", {29'b0, count}, 32'd4);
         exp_pc = exp_pc + 32'd1;
      end

      // Redirect storm: last target wins
      redirect = 1'b1;
      redirect_pc = 32'd5;
      tick();
      check("storm_count1", {29'b0, count}, 32'd0);
      redirect_pc = 32'd9;
      tick();
      check("storm_addr2", imem_addr, 32'd9);
      redirect_pc = 32'd13;
      tick();
      check("storm_addr3", imem_addr, 32'd13);
      check("storm_count3", {29'b0, count}, 32'd0);
      redirect = 1'b0;
      instr_ready = 1'b0;
      tick();
      check("storm_instr", instr_out, 32'h10D);
      check("storm_pc1", pcplus1_out, 32'd14);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("storm_count_bound", {31'b0, (count <= 3'd4)}, 32'd1);
      end
      check("storm_full", {29'b0, count}, 32'd4);
      instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("storm_drain", instr_out, 32'h10D + 32'(k));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
